// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// A start in IDLE gives 32 shift-add or restoring-divide iterations, then one finalize edge.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [DW-1:0]      mul_next;
    logic [WIDTH:0]     div_tmp, div_diff;
    logic [DW-1:0]      div_next;
    logic [DW-1:0]      prod;
    logic [WIDTH-1:0]   quo, rem;

    // Operand magnitudes for signed ops, taken at capture
    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && a[WIDTH-1]) ? WIDTH'(-a) : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? WIDTH'(-b) : b;
    end

    // One iteration of each algorithm; acc holds {upper, multiplier/dividend bits}
    always_comb begin
        mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opa_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[DW-1:1]};
        div_tmp  = acc_q[DW-1:WIDTH-1];
        div_diff = div_tmp - {1'b0, opb_q};
        div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction applied on the finalize edge
    always_comb begin
        prod = neg_q ? DW'(-acc_q) : acc_q;
        quo  = neg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? WIDTH'(-acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dbz_flag_d = dbz_flag_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    last_d     = 1'b0;
                    opa_d      = a_mag;
                    opb_d      = b_mag;
                    is_div_d   = op[1];
                    neg_d      = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = signed_op & a[WIDTH-1];
                    dbz_flag_d = op[1] & (b == '0);
                    acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                end
            end
            S_RUN: begin
                if (last_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod[DW-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (dbz_flag_q) begin
                        // Divide by zero returns all-ones quotient and the original dividend
                        dbz_d = 1'b1;
                        lo_d  = '1;
                        hi_d  = neg_rem_q ? WIDTH'(-opa_q) : opa_q;
                    end else begin
                        lo_d = quo;
                        hi_d = rem;
                    end
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        last_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dbz_flag_q <= dbz_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            2'b00: begin
                q = sa * sb;
                return {1'b0, 64'(q)};
            end
            2'b01: begin
                p = {32'd0, ma} * {32'd0, mb};
                return {1'b0, p};
            end
            2'b10: begin
                if (mb == 32'd0) return {1'b1, ma, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (mb == 32'd0) return {1'b1, ma, 32'hFFFF_FFFF};
                return {1'b0, ma % mb, ma / mb};
            end
        endcase
    endfunction

    // Called just after a rising edge; start is sampled at the next edge E.
    // inject > 0 pulses start with fresh operands into edge E+inject.
    task automatic run_op(input logic [1:0] top, input logic [31:0] ta, input logic [31:0] tb,
                          input int inject);
        logic [64:0] exp;
        int          ndone;
        exp   = model(top, ta, tb);
        ndone = 0;
        start = 1'b1;
        op    = top;
        a     = ta;
        b     = tb;
        @(posedge clk);
        #1;
        chk("start_busy", {64'd0, busy, done, div_by_zero}, {64'd0, 3'b100});
        for (int k = 1; k <= 34; k++) begin
            start = (k == inject);
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (k <= 32)
                chk("run_busy", {64'd0, busy, done, div_by_zero}, {64'd0, 3'b100});
            else if (k == 33) begin
                chk("done_flags", {64'd0, busy, done, div_by_zero}, {64'd0, 2'b01, exp[64]});
                chk("result", {3'd0, hi, lo}, {3'd0, exp[63:0]});
            end else
                chk("idle_flags", {64'd0, busy, done, div_by_zero}, 67'd0);
        end
        start = 1'b0;
        chk("one_done", 67'(ndone), 67'd1);
    endtask

    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_const", {3'd0, hi, lo}, {3'd0, 64'hFFFF_FFFE_0000_0001});
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        chk("mult_neg_const", {3'd0, hi, lo}, {3'd0, 64'hFFFF_FFFF_FFFF_FFF1});
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg_const", {3'd0, hi, lo}, {3'd0, 64'hFFFF_FFFF_FFFF_FFFD});
        run_op(2'b11, 32'd100, 32'd7, 0);
        chk("divu_const", {3'd0, hi, lo}, {3'd0, 32'd2, 32'd14});
        run_op(2'b11, 32'd100, 32'd0, 0);
        chk("divu_zero_const", {3'd0, hi, lo}, {3'd0, 32'd100, 32'hFFFF_FFFF});
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_wrap_const", {3'd0, hi, lo}, {3'd0, 32'd0, 32'h8000_0000});
        run_op(2'b10, 32'h8000_0003, 32'd0, 0);

        // Start rejected while running; results hold afterwards
        run_op(2'b01, 32'd2, 32'd3, 10);
        chk("reject_const", {3'd0, hi, lo}, {3'd0, 32'd0, 32'd6});
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            chk("hold", {busy, done, div_by_zero, hi, lo}, {3'b000, 32'd0, 32'd6});
        end

        // Reset aborts an operation in flight
        start = 1'b1;
        op    = 2'b11;
        a     = $urandom;
        b     = $urandom_range(1, 1000);
        @(posedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("abort_quiet", {64'd0, busy, done, div_by_zero}, 67'd0);
            if (i == 2) reset_n = 1'b1;
        end
        run_op(2'b01, 32'd4, 32'd4, 0);
        chk("after_reset_const", {3'd0, hi, lo}, {3'd0, 32'd0, 32'd16});

        // Randomized operations, occasional zero divisors and extreme operands
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ((n % 6) == 5) rb = 32'd0;
            if ((n % 8) == 3) ra = 32'h8000_0000;
            if ((n % 5) == 2) rb = 32'($urandom_range(1, 15));
            run_op(rop, ra, rb, (n % 4 == 1) ? int'($urandom_range(1, 33)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
